path_tracer: RTL and testbench
==============================

// Module: path_tracer
// PURPOSE
//  Consumer of the Dijkstra solver's result: takes one solved query (found flag, path_matrix, start/end, length)
//  and walks the marked path, streaming node numbers start->end one per beat over a valid/ready port.
//  Sits between the combinational Dijkstra block and any sequential sink (move sequencer, UART dumper).
//  Node n (1..9, row-major from top-left) maps to grid/path bit (9-n); node 1 = bit 8, node 9 = bit 0.
// PARAMETERS
//  GRID_DIM   3   grid side; N = GRID_DIM*GRID_DIM nodes (only 3 is verified)
//  NODE_W     4   width of node-number fields
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       query present
//  in_ready   out  1       tracer idle, query accepted when in_valid&&in_ready
//  in_found   in   1       solver's shortest_path_found
//  in_path    in   N       solver's path_matrix (1 = node on path)
//  in_start   in   NODE_W  start node 1..N
//  in_end     in   NODE_W  end node 1..N
//  in_length  in   NODE_W  solver's shortest_path_length (moves = nodes-1)
//  out_valid  out  1       beat present
//  out_ready  in   1       sink accepts beat
//  out_node   out  NODE_W  current node number (0 on error-only beat)
//  out_last   out  1       final beat of this query
//  out_err    out  1       beat carries an error; always with out_last
//  err_code   out  2       01 bad query, 10 broken path, 11 length mismatch; 00 otherwise
// BEHAVIOUR
//  Reset: in_ready=0 during rst, 1 first cycle after; out_valid/out_last/out_err=0, out_node=0, err_code=00.
//  FSM IDLE -> EMIT -> (STEP -> EMIT)* -> IDLE. ERR beat is an EMIT with out_err=1.
//  IDLE: in_ready=1; on accept latch all in_* and set visited mask={start}; go EMIT next cycle (latency 1).
//   Bad query (in_found=0, start/end outside 1..N, or start/end bit clear in in_path): single beat node=0, err=1, last=1, code 01.
//  EMIT: out_valid=1, out_node=current. All out_* held stable while out_valid&&!out_ready.
//   current==end: out_last=1; on accept -> IDLE (in_ready=1 the following cycle).
//   else on accept -> STEP.
//  STEP (1 cycle): next = first 4-neighbour with path bit set and not visited, priority right, down, left, up
//   (no wrap across row edges). Found: current=next, mark visited, moves++, -> EMIT. None: -> EMIT error beat,
//   node=0, code 10, last=1. Throughput: one beat per 2 cycles under full out_ready.
//  moves counter saturates at N-1; reaching N-1 without end is code 10.
//  in_* ignored while not IDLE; no query lost or queued.
//  rst mid-walk: next cycle FSM=IDLE, out_valid=0, latched query discarded.
// CONFIGURATION
//  PATH_TRACER_LEN_CHECK_EN defined: on the end-node beat compare moves to latched in_length; mismatch sets
//   out_err=1, code 11 on that same beat (out_node=end, out_last=1).
//  Undefined: in_length unused, no mismatch check, code 11 never produced.
// STRUCTURE
//  dijkstra_pkg: GRID_DIM, node_to_bit() function, err code localparams (ERR_NONE/BAD/BROKEN/LEN), FSM state enum.
//  Sub-module path_next_node: combinational neighbour selector (current, path, visited -> next, found).
// TESTING
//  T1 in_path=9'b111001001, start 1, end 9, found 1, len 4 -> beats 1,2,3,6,9; last on 9; no err.
//  T2 found=0, path 9'b111010111 -> one beat node 0, err=1, last=1, code 01.
//  T3 path 9'b100010001, start 1, end 9, found 1 -> beat 1, then node 0, err=1, code 10.
//  T4 T1 with out_ready low 3 cycles at node 3 -> out_node=3 stable, no skip, sequence unchanged.
//  T5 T1 with len 3: macro on -> final beat node 9, err=1, code 11; macro off -> clean as T1.
//  T6 rst asserted after beat 2 of T1 -> out_valid=0 next cycle, in_ready=1 after rst drops; fresh T1 runs cleanly.

Source files
------------

// File: rtl/dijkstra_pkg.sv
// Shared constants, error codes, FSM states and node/bit helpers for the path tracer.
// Build option PATH_TRACER_LEN_CHECK_EN (see path_tracer.sv) enables the length-mismatch check.
package dijkstra_pkg;

    localparam int unsigned GRID_DIM = 3;
    localparam int unsigned N_NODES  = GRID_DIM * GRID_DIM;
    localparam int unsigned NODE_W   = 4;
    localparam int unsigned ERR_W    = 2;

    localparam logic [ERR_W-1:0] ERR_NONE   = 2'b00;
    localparam logic [ERR_W-1:0] ERR_BAD    = 2'b01;
    localparam logic [ERR_W-1:0] ERR_BROKEN = 2'b10;
    localparam logic [ERR_W-1:0] ERR_LEN    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_STEP
    } state_e;

    // Output beat payload as held in the output register.
    typedef struct packed {
        logic              valid;
        logic [NODE_W-1:0] node;
        logic              last;
        logic              err;
        logic [ERR_W-1:0]  code;
    } beat_t;

    // Node 1 is the MSB of the path vector, node N the LSB.
    function automatic logic [NODE_W-1:0] node_to_bit(input logic [NODE_W-1:0] node);
        return NODE_W'(N_NODES) - node;
    endfunction

    function automatic logic node_in_range(input logic [NODE_W-1:0] node);
        return (node >= NODE_W'(1)) && (node <= NODE_W'(N_NODES));
    endfunction

endpackage

// File: rtl/path_next_node.sv
// Combinational neighbour selector: first unvisited on-path 4-neighbour of the current
// node, priority right, down, left, up, with no wrap across row edges.
module path_next_node
    import dijkstra_pkg::*;
(
    input  logic [NODE_W-1:0]  cur,
    input  logic [N_NODES-1:0] path,
    input  logic [N_NODES-1:0] visited,
    output logic [NODE_W-1:0]  next_c,
    output logic               found_c
);

    logic [NODE_W-1:0] idx;
    logic [NODE_W-1:0] row;
    logic [NODE_W-1:0] col;
    logic [NODE_W-1:0] cand [4];
    logic [3:0]        edge_ok;

    always_comb begin
        next_c  = '0;
        found_c = 1'b0;
        idx     = cur - NODE_W'(1);
        row     = idx / NODE_W'(GRID_DIM);
        col     = idx % NODE_W'(GRID_DIM);

        cand[0] = cur + NODE_W'(1);
        cand[1] = cur + NODE_W'(GRID_DIM);
        cand[2] = cur - NODE_W'(1);
        cand[3] = cur - NODE_W'(GRID_DIM);

        edge_ok[0] = (col != NODE_W'(GRID_DIM - 1));
        edge_ok[1] = (row != NODE_W'(GRID_DIM - 1));
        edge_ok[2] = (col != NODE_W'(0));
        edge_ok[3] = (row != NODE_W'(0));

        // Scan lowest priority first so the highest-priority hit wins.
        for (int d = 3; d >= 0; d--) begin
            if (edge_ok[d] && path[node_to_bit(cand[d])] && !visited[node_to_bit(cand[d])]) begin
                next_c  = cand[d];
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/path_tracer.sv
// Walks a solved Dijkstra path and streams node numbers start->end over valid/ready.
// Define PATH_TRACER_LEN_CHECK_EN to flag a move count that disagrees with in_length.
module path_tracer
    import dijkstra_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_found,
    input  logic [N_NODES-1:0] in_path,
    input  logic [NODE_W-1:0]  in_start,
    input  logic [NODE_W-1:0]  in_end,
    input  logic [NODE_W-1:0]  in_length,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NODE_W-1:0]  out_node,
    output logic               out_last,
    output logic               out_err,
    output logic [ERR_W-1:0]   err_code
);

    state_e             state_q, state_d;
    logic [NODE_W-1:0]  cur_q, cur_d;
    logic [NODE_W-1:0]  end_q, end_d;
    logic [N_NODES-1:0] path_q, path_d;
    logic [N_NODES-1:0] visited_q, visited_d;
    logic [NODE_W-1:0]  moves_q, moves_d;
    beat_t              beat_q, beat_d;
    logic               in_ready_q, in_ready_d;

    logic              accept;
    logic              bad_query;
    logic [NODE_W-1:0] next_node;
    logic              next_found;
    logic              len_mis_idle;
    logic              len_mis_step;

    path_next_node u_next (
        .cur     (cur_q),
        .path    (path_q),
        .visited (visited_q),
        .next_c  (next_node),
        .found_c (next_found)
    );

    assign accept    = in_valid && in_ready_q && (state_q == ST_IDLE);
    assign bad_query = !in_found || !node_in_range(in_start) || !node_in_range(in_end)
                       || !in_path[node_to_bit(in_start)] || !in_path[node_to_bit(in_end)];

`ifdef PATH_TRACER_LEN_CHECK_EN
    logic [NODE_W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
        end else if (accept) begin
            len_q <= in_length;
        end
    end

    // Zero moves when start==end; otherwise compare the move count after this step.
    assign len_mis_idle = (in_length != NODE_W'(0));
    assign len_mis_step = ((moves_q + NODE_W'(1)) != len_q);
`else
    logic len_unused;
    assign len_unused   = ^in_length;
    assign len_mis_idle = 1'b0;
    assign len_mis_step = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            end_q      <= '0;
            path_q     <= '0;
            visited_q  <= '0;
            moves_q    <= '0;
            beat_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            end_q      <= end_d;
            path_q     <= path_d;
            visited_q  <= visited_d;
            moves_q    <= moves_d;
            beat_q     <= beat_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        end_d      = end_q;
        path_d     = path_q;
        visited_d  = visited_q;
        moves_d    = moves_q;
        beat_d     = beat_q;
        in_ready_d = in_ready_q;

        unique case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    in_ready_d   = 1'b0;
                    state_d      = ST_EMIT;
                    beat_d.valid = 1'b1;
                    if (bad_query) begin
                        beat_d.node = '0;
                        beat_d.last = 1'b1;
                        beat_d.err  = 1'b1;
                        beat_d.code = ERR_BAD;
                    end else begin
                        cur_d       = in_start;
                        end_d       = in_end;
                        path_d      = in_path;
                        visited_d   = N_NODES'(1) << node_to_bit(in_start);
                        moves_d     = '0;
                        beat_d.node = in_start;
                        beat_d.last = (in_start == in_end);
                        beat_d.err  = (in_start == in_end) && len_mis_idle;
                        beat_d.code = beat_d.err ? ERR_LEN : ERR_NONE;
                    end
                end
            end

            ST_EMIT: begin
                if (out_ready) begin
                    if (beat_q.last) begin
                        state_d    = ST_IDLE;
                        beat_d     = '0;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d      = ST_STEP;
                        beat_d.valid = 1'b0;
                    end
                end
            end

            ST_STEP: begin
                state_d      = ST_EMIT;
                beat_d.valid = 1'b1;
                if (next_found && (moves_q < NODE_W'(N_NODES - 1))) begin
                    cur_d       = next_node;
                    visited_d   = visited_q | (N_NODES'(1) << node_to_bit(next_node));
                    moves_d     = moves_q + NODE_W'(1);
                    beat_d.node = next_node;
                    beat_d.last = (next_node == end_q);
                    beat_d.err  = (next_node == end_q) && len_mis_step;
                    beat_d.code = beat_d.err ? ERR_LEN : ERR_NONE;
                end else begin
                    beat_d.node = '0;
                    beat_d.last = 1'b1;
                    beat_d.err  = 1'b1;
                    beat_d.code = ERR_BROKEN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = beat_q.valid;
    assign out_node  = beat_q.node;
    assign out_last  = beat_q.last;
    assign out_err   = beat_q.err;
    assign err_code  = beat_q.code;

endmodule

// File: tb/tb_path_tracer.sv
// Directed bench for path_tracer: a grid-walk reference model produces the expected
// beat stream and a negedge monitor checks every handshaken beat and every stall.
module tb_path_tracer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_found;
    logic [8:0] in_path;
    logic [3:0] in_start;
    logic [3:0] in_end;
    logic [3:0] in_length;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_node;
    logic       out_last;
    logic       out_err;
    logic [1:0] err_code;

`ifdef PATH_TRACER_LEN_CHECK_EN
    localparam bit LEN_ON = 1'b1;
`else
    localparam bit LEN_ON = 1'b0;
`endif

    typedef struct {
        int node;
        bit last;
        bit err;
        int code;
    } exp_t;

    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   beats_seen;
    bit   got_last;
    bit   held;
    int   h_node, h_last, h_err, h_code;

    path_tracer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_found  (in_found),
        .in_path   (in_path),
        .in_start  (in_start),
        .in_end    (in_end),
        .in_length (in_length),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_node  (out_node),
        .out_last  (out_last),
        .out_err   (out_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic push_exp(input int n, input bit l, input bit e, input int c);
        exp_t b;
        b.node = n; b.last = l; b.err = e; b.code = c;
        exp_q.push_back(b);
    endtask

    // Reference: walk the grid in (row, col) coordinates following the neighbour rule.
    task automatic gen_expect(input bit found, input logic [8:0] path, input int s,
                              input int e, input int len);
        int  dr [4] = '{0, 1, 0, -1};
        int  dc [4] = '{1, 0, -1, 0};
        bit  vis [10];
        int  r, c, nr, nc, n, n2, moves;
        bit  moved, mism;
        exp_q.delete();
        if (!found || s < 1 || s > 9 || e < 1 || e > 9 || !path[9-s] || !path[9-e]) begin
            push_exp(0, 1'b1, 1'b1, 1);
            return;
        end
        foreach (vis[i]) vis[i] = 1'b0;
        r = (s - 1) / 3; c = (s - 1) % 3; moves = 0; vis[s] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n = r * 3 + c + 1;
            if (n == e) begin
                mism = LEN_ON && (moves != len);
                push_exp(n, 1'b1, mism, mism ? 3 : 0);
                return;
            end
            push_exp(n, 1'b0, 1'b0, 0);
            moved = 1'b0;
            for (int d = 0; d < 4; d++) begin
                nr = r + dr[d]; nc = c + dc[d];
                if (!moved && moves < 8 && nr >= 0 && nr < 3 && nc >= 0 && nc < 3) begin
                    n2 = nr * 3 + nc + 1;
                    if (path[9-n2] && !vis[n2]) begin
                        r = nr; c = nc; vis[n2] = 1'b1; moves++; moved = 1'b1;
                    end
                end
            end
            if (!moved) begin
                push_exp(0, 1'b1, 1'b1, 2);
                return;
            end
        end
    endtask

    task automatic send_query(input bit found, input logic [8:0] path, input int s,
                              input int e, input int len);
        int w = 0;
        got_last = 1'b0;
        beats_seen = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_query", int'(in_ready), 1);
        in_valid  = 1'b1;
        in_found  = found;
        in_path   = path;
        in_start  = 4'(s);
        in_end    = 4'(e);
        in_length = 4'(len);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_found = 1'b0; in_path = '0; in_start = '0; in_end = '0; in_length = '0;
        chk("accept_latency_valid", int'(out_valid), 1);
    endtask

    task automatic run_query(input string nm, input bit found, input logic [8:0] path,
                             input int s, input int e, input int len,
                             input int stall_n, input int stall_c);
        int nbeats, cycles, stall_left;
        gen_expect(found, path, s, e, len);
        nbeats = exp_q.size();
        send_query(found, path, s, e, len);
        cycles = 0;
        stall_left = stall_c;
        while (!got_last && cycles < 100) begin
            if (out_valid && int'(out_node) == stall_n && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); cycles++; #1;
        end
        out_ready = 1'b1;
        chk({nm, "_last_seen"}, int'(got_last), 1);
        chk({nm, "_beats_left"}, exp_q.size(), 0);
        chk({nm, "_beat_count"}, beats_seen, nbeats);
        chk({nm, "_cycles"}, cycles, 2 * nbeats - 1 + stall_c);
        chk({nm, "_ready_after"}, int'(in_ready), 1);
        chk({nm, "_valid_after"}, int'(out_valid), 0);
        exp_q.delete();
    endtask

    // Monitor: consume one expected beat per handshake; stalled beats must hold.
    initial begin
        exp_t b;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_node", int'(out_node), h_node);
                    chk("hold_last", int'(out_last), h_last);
                    chk("hold_err", int'(out_err), h_err);
                    chk("hold_code", int'(err_code), h_code);
                end
                held = 1'b0;
                if (out_valid && out_err) chk("err_implies_last", int'(out_last), 1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat_node", int'(out_node), -1);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_node", int'(out_node), b.node);
                        chk("beat_last", int'(out_last), int'(b.last));
                        chk("beat_err", int'(out_err), int'(b.err));
                        chk("beat_code", int'(err_code), b.code);
                    end
                    beats_seen++;
                    if (out_last) got_last = 1'b1;
                end else if (out_valid) begin
                    held = 1'b1;
                    h_node = int'(out_node); h_last = int'(out_last);
                    h_err = int'(out_err); h_code = int'(err_code);
                end
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; in_found = 1'b0; in_path = '0;
        in_start = '0; in_end = '0; in_length = '0; out_ready = 1'b1;
        got_last = 1'b0; beats_seen = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_node", int'(out_node), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_code", int'(err_code), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Pin the reference model against hand-derived sequences.
        gen_expect(1'b1, 9'b111001001, 1, 9, 4);
        chk("model_t1_size", exp_q.size(), 5);
        chk("model_t1_n0", exp_q[0].node, 1);
        chk("model_t1_n2", exp_q[2].node, 3);
        chk("model_t1_n3", exp_q[3].node, 6);
        chk("model_t1_n4", exp_q[4].node, 9);
        chk("model_t1_last", int'(exp_q[4].last), 1);
        gen_expect(1'b0, 9'b111010111, 1, 9, 4);
        chk("model_t2_size", exp_q.size(), 1);
        chk("model_t2_code", exp_q[0].code, 1);
        gen_expect(1'b1, 9'b100010001, 1, 9, 2);
        chk("model_t3_size", exp_q.size(), 2);
        chk("model_t3_code", exp_q[1].code, 2);
        chk("model_t3_node", exp_q[1].node, 0);
        gen_expect(1'b1, 9'b111001001, 1, 9, 3);
        chk("model_t5_err", int'(exp_q[4].err), int'(LEN_ON));
        chk("model_t5_code", exp_q[4].code, LEN_ON ? 3 : 0);
        exp_q.delete();

        run_query("t1", 1'b1, 9'b111001001, 1, 9, 4, -1, 0);
        run_query("t2", 1'b0, 9'b111010111, 1, 9, 4, -1, 0);
        run_query("t3", 1'b1, 9'b100010001, 1, 9, 2, -1, 0);
        run_query("t4", 1'b1, 9'b111001001, 1, 9, 4, 3, 3);
        run_query("t5", 1'b1, 9'b111001001, 1, 9, 3, -1, 0);
        run_query("reverse", 1'b1, 9'b111001001, 9, 1, 4, -1, 0);
        run_query("self", 1'b1, 9'b000010000, 5, 5, 0, -1, 0);
        run_query("start_zero", 1'b1, 9'b111001001, 0, 9, 4, -1, 0);
        run_query("end_range", 1'b1, 9'b111001001, 1, 10, 4, -1, 0);
        run_query("end_bit_clear", 1'b1, 9'b111001000, 1, 9, 4, -1, 0);
        run_query("no_wrap", 1'b1, 9'b001100000, 3, 4, 1, -1, 0);
        run_query("priority_dead", 1'b1, 9'b110100111, 1, 9, 4, -1, 0);
        run_query("stall_err", 1'b1, 9'b100010001, 1, 9, 2, 0, 2);

        // Reset in the middle of a walk, then a fresh clean query.
        gen_expect(1'b1, 9'b111001001, 1, 9, 4);
        send_query(1'b1, 9'b111001001, 1, 9, 4);
        w = 0;
        while (beats_seen < 2 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("t6_two_beats", beats_seen, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_ready", int'(in_ready), 0);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("t6_ready_after_rst", int'(in_ready), 1);
        chk("t6_valid_after_rst", int'(out_valid), 0);
        run_query("t6_fresh", 1'b1, 9'b111001001, 1, 9, 4, -1, 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
